edge_phase_sched: RTL



---
 rtl/edge_phase_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/edge_phase_sched.sv
// edge_phase_sched: multi-phase enable sequencer for positive-edge clock gates.
// Each gated domain gets exactly one rising clk edge per machine cycle, in phase order.
//
// Ports:
//   clk       free-running clock, also fed to every edge gate
//   rst_n     synchronous active-low reset
//   run       level, request free-running execution
//   step      pulse, request one machine cycle when idle
//   halt_req  level, stop at the next machine-cycle boundary
//   stall     level, hold phase and suppress edges this cycle
//   en        registered one-hot-or-zero gate enables
//   phase     index of the next phase to issue
//   busy      high whenever not IDLE
//   done      one-cycle pulse on the first IDLE cycle after a sequence ends
//
// Optional: define EDGE_PHASE_SCHED_CYCLE_COUNT_EN to add
//   cycle_cnt (16-bit machine-cycle counter) and clr_cnt (counter clear).

module edge_phase_sched #(
    parameter int NPHASE = 4,
    parameter int PW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              stall,
`ifdef EDGE_PHASE_SCHED_CYCLE_COUNT_EN
    output logic [15:0]       cycle_cnt,
    input  logic              clr_cnt,
`endif
    output logic [NPHASE-1:0] en,
    output logic [PW-1:0]     phase,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [NPHASE-1:0]   en_q, en_d;
    logic                done_q, done_d;
    logic                issue;
    logic                last;

    assign last = (phase_q == PW'(NPHASE - 1));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // halt_req outranks run, run outranks step
                if (!halt_req && !stall && run) begin
                    state_d = RUN;
                    issue   = 1'b1;
                end else if (!halt_req && !stall && step) begin
                    state_d = STEP;
                    issue   = 1'b1;
                end
            end
            RUN: begin
                issue = !stall;
                // A stop request is latched even while stalled; if it
                // coincides with the last phase, there is nothing to drain.
                if (halt_req || !run) begin
                    state_d = (issue && last) ? IDLE : DRAIN;
                end
            end
            STEP, DRAIN: begin
                issue = !stall;
                if (issue && last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        en_d    = '0;
        if (issue) begin
            en_d    = {{(NPHASE-1){1'b0}}, 1'b1} << phase_q;
            phase_d = last ? '0 : phase_q + PW'(1);
        end
    end

    assign done_d = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign en    = en_q;
    assign phase = phase_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

`ifdef EDGE_PHASE_SCHED_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (issue && last) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule
